// File: rtl/matvec_seq_ctrl.sv
// Sequencer for one 6x6-by-6 multiply-accumulate pass: launches the multiplier array, then the
// row adder trees, captures the six row sums and serves them through a registered read port.
module matvec_seq_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         mul_start,
  input  logic         mul_valid,
  output logic         tree_start,
  input  logic         tree_valid,
  input  logic [191:0] s192,
  input  logic [2:0]   rd_idx,
  output logic [31:0]  rd_data,
  output logic [15:0]  cycle_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StMulIssue,
    StMulWait,
    StAddIssue,
    StAddWait,
    StDone
  } state_t;

  localparam logic [15:0] WaitLimit = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] wait_cnt_q;
  logic [15:0] busy_cnt_q;
  logic [15:0] busy_cnt_inc;
  logic [31:0] res_q [6];
  logic        timeout;
  logic        accept;
  logic        capture;
  logic        in_wait;

  assign accept       = (state_q == StIdle) && start;
  assign capture      = (state_q == StAddWait) && tree_valid;
  assign in_wait      = (state_q == StMulWait) || (state_q == StAddWait);
  assign busy_cnt_inc = (busy_cnt_q == 16'hFFFF) ? busy_cnt_q : busy_cnt_q + 16'd1;

  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    unique case (state_q)
      StIdle:     if (start) state_d = StMulIssue;
      StMulIssue: state_d = StMulWait;
      StMulWait: begin
        if (mul_valid) begin
          state_d = StAddIssue;
        end else if (wait_cnt_q == WaitLimit) begin
          state_d = StIdle;
          timeout = 1'b1;
        end
      end
      StAddIssue: state_d = StAddWait;
      StAddWait: begin
        if (tree_valid) begin
          state_d = StDone;
        end else if (wait_cnt_q == WaitLimit) begin
          state_d = StIdle;
          timeout = 1'b1;
        end
      end
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      mul_start  <= 1'b0;
      tree_start <= 1'b0;
      rd_data    <= '0;
      cycle_cnt  <= '0;
      wait_cnt_q <= '0;
      busy_cnt_q <= '0;
      for (int r = 0; r < 6; r++) res_q[r] <= '0;
    end else begin
      state_q    <= state_d;
      // Outputs are decoded from the next state so they line up with the state they belong to.
      busy       <= (state_d != StIdle);
      done       <= (state_d == StDone);
      mul_start  <= (state_d == StMulIssue);
      tree_start <= (state_d == StAddIssue);

      if (state_d != state_q) begin
        wait_cnt_q <= '0;
      end else if (in_wait) begin
        wait_cnt_q <= wait_cnt_q + 16'd1;
      end

      if (accept) begin
        busy_cnt_q <= '0;
      end else if (state_q inside {StMulIssue, StMulWait, StAddIssue, StAddWait}) begin
        busy_cnt_q <= busy_cnt_inc;
      end

      if (accept) begin
        err <= 1'b0;
      end else if (timeout) begin
        err <= 1'b1;
      end

      if (capture) begin
        cycle_cnt <= busy_cnt_inc;
        for (int r = 0; r < 6; r++) res_q[r] <= s192[32*r +: 32];
      end

      // Reads see the result registers as they were before this edge.
      rd_data <= (rd_idx < 3'd6) ? res_q[rd_idx] : 32'h0;
    end
  end

endmodule

// File: doc/matvec_seq_ctrl.md
MATVEC_SEQ_CTRL -- requirements
Module: matvec_seq_ctrl

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT, default 255, maximum cycles spent in any wait state before abort (legal range 1..65535).
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
 clk  input  1  single clock; all state updates on rising edge
 resetn  input  1  asynchronous, active-low reset
 start  input  1  request one 6x6-by-6 multiply-accumulate pass
 busy  output  1  pass in progress
 done  output  1  one-cycle pulse, pass completed and results captured
 err  output  1  sticky timeout flag
 mul_start  output  1  one-cycle pulse launching the 36-product multiplier array
 mul_valid  input  1  multiplier array products (1152-bit bus) stable
 tree_start  output  1  one-cycle pulse launching the six-row adder tree
 tree_valid  input  1  AND of all six row-tree valids; S192 stable
 s192  input  192  six 32-bit row sums, row r at bits [32r+31:32r]
 rd_idx  input  3  result row select
 rd_data  output  32  registered result row
 cycle_cnt  output  16  busy cycles consumed by last successful pass

Function
REQ-003 The controller SHALL be a Moore FSM with states IDLE, MUL_ISSUE, MUL_WAIT, ADD_ISSUE, ADD_WAIT, DONE; encoding is free.
REQ-004 IDLE: start=1 -> MUL_ISSUE; otherwise stay.
REQ-005 MUL_ISSUE SHALL last exactly one cycle with mul_start=1, then -> MUL_WAIT.
REQ-006 MUL_WAIT: mul_valid=1 -> ADD_ISSUE; mul_valid is ignored in every other state.
REQ-007 ADD_ISSUE SHALL last exactly one cycle with tree_start=1, then -> ADD_WAIT.
REQ-008 ADD_WAIT: tree_valid=1 -> DONE, and s192 SHALL be captured into six 32-bit result registers on that same edge; tree_valid is ignored in every other state.
REQ-009 DONE SHALL last exactly one cycle with done=1, then -> IDLE.
REQ-010 busy SHALL be 1 in every state except IDLE.
REQ-011 start SHALL be ignored in every state except IDLE, including DONE; the block has no request queue.
REQ-012 Minimum latency: start sampled at edge N -> mul_start high in cycle N+1 -> tree_start high in cycle N+3 -> done high in cycle N+5, when each valid is high in the first cycle of its wait state.
REQ-013 Wait counter: cleared on entry to MUL_WAIT and to ADD_WAIT; increments each wait cycle in which the awaited valid is 0.
REQ-014 In a wait state, if the valid is 0 and the wait counter equals TIMEOUT-1, the next state SHALL be IDLE with err set to 1; no done is issued and the result registers are unchanged.
REQ-015 If the valid is 1 in the final permitted wait cycle, the valid SHALL win and no timeout occurs.
REQ-016 err SHALL stay 1 until the next accepted start, which clears it on the same edge.
REQ-017 Busy counter: cleared on the edge that accepts start; increments once per cycle in MUL_ISSUE through ADD_WAIT; saturates at 65535.
REQ-018 cycle_cnt SHALL load the busy counter value on entry to DONE only; it is unchanged by a timed-out pass.
REQ-019 rd_data SHALL be registered, giving result row rd_idx one cycle after rd_idx is presented; rd_idx 6 or 7 SHALL return 0.
REQ-020 Results written in the same edge as a read SHALL appear on rd_data one cycle later; the old value is returned for that read.

Reset
REQ-021 resetn=0 SHALL asynchronously force state IDLE and zero all of: busy, done, err, mul_start, tree_start, rd_data, cycle_cnt, wait and busy counters, and the result registers.
REQ-022 Reset asserted mid-pass SHALL abort the pass with no done pulse; the first start after resetn rises SHALL be accepted normally.

Verification
REQ-023 Start pulse; mul_valid and tree_valid high on the first wait cycle; s192 row r = r+1 -> done at start+5, cycle_cnt=4, rd_idx=0..5 returns 1..6, rd_idx=7 returns 0.
REQ-024 Start; mul_valid delayed 10 cycles and tree_valid delayed 3 cycles -> exactly one mul_start and one tree_start pulse, done once, cycle_cnt=17.
REQ-025 TIMEOUT=4; mul_valid never asserted -> exactly 4 cycles in MUL_WAIT, then IDLE, err=1, no done, results and cycle_cnt unchanged; next start clears err.
REQ-026 TIMEOUT=4; tree_valid rises on the 4th ADD_WAIT cycle -> done, err=0.
REQ-027 start held high continuously -> back-to-back passes, one IDLE cycle between done and the next mul_start; start pulses during busy are ignored.
REQ-028 resetn pulsed low during ADD_WAIT -> all outputs 0 immediately; no done; a fresh start completes normally.
